// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial_ctrl (plus its 1-bit slice, alu_top)
// Brief    : Bit-serial ALU sequencer, one slice step per clock, LSB first.
//            Optional abort input enabled by `define ALU_SERIAL_ABORT_EN.
// Revision : 1.0
// ============================================================================

module alu_top (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       less_i,
  input  logic       a_inv_i,
  input  logic       b_inv_i,
  input  logic       cin_i,
  input  logic [1:0] op_i,
  output logic       result_o,
  output logic       cout_o
);

  logic a_eff;
  logic b_eff;

  assign a_eff  = a_i ^ a_inv_i;
  assign b_eff  = b_i ^ b_inv_i;
  assign cout_o = (a_eff & b_eff) | (a_eff & cin_i) | (b_eff & cin_i);

  always_comb begin
    result_o = 1'b0;
    case (op_i)
      2'b00:   result_o = a_eff & b_eff;
      2'b01:   result_o = a_eff | b_eff;
      2'b10:   result_o = a_eff ^ b_eff ^ cin_i;
      default: result_o = less_i;
    endcase
  end

endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
`ifdef ALU_SERIAL_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [3:0]       ctrl_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             msb_sum_q;
  logic             ovf_sub_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, cout_q, ovf_q;

  logic             abort;
  logic             a_inv, b_inv, op_valid, is_arith, is_addsub;
  logic [1:0]       slice_op;
  logic             start_b_inv;
  logic             a_bit, b_bit;
  logic             slice_res, slice_cout;
  logic             msb_sum, ovf_step, last_step;
  logic [WIDTH-1:0] res_next;
  logic             slt_set;

`ifdef ALU_SERIAL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    a_inv    = 1'b0;
    b_inv    = 1'b0;
    slice_op = 2'b00;
    op_valid = 1'b1;
    case (ctrl_q)
      OP_AND: slice_op = 2'b00;
      OP_OR:  slice_op = 2'b01;
      OP_ADD: slice_op = 2'b10;
      OP_SUB: begin b_inv = 1'b1; slice_op = 2'b10; end
      OP_SLT: begin b_inv = 1'b1; slice_op = 2'b11; end
      OP_NOR: begin a_inv = 1'b1; b_inv = 1'b1; slice_op = 2'b00; end
      default: op_valid = 1'b0;
    endcase
  end

  assign is_addsub   = (ctrl_q == OP_ADD) || (ctrl_q == OP_SUB);
  assign is_arith    = is_addsub || (ctrl_q == OP_SLT);
  // The carry flop doubles as the +1 of two's-complement negation.
  assign start_b_inv = (ctrl_i == OP_SUB) || (ctrl_i == OP_SLT) || (ctrl_i == OP_NOR);

  assign a_bit = a_q[idx_q];
  assign b_bit = b_q[idx_q];

  alu_top u_slice (
    .a_i      (a_bit),
    .b_i      (b_bit),
    .less_i   (1'b0),
    .a_inv_i  (a_inv),
    .b_inv_i  (b_inv),
    .cin_i    (carry_q),
    .op_i     (slice_op),
    .result_o (slice_res),
    .cout_o   (slice_cout)
  );

  // The slice reports `less` for SLT, so the MSB sum is rebuilt here.
  assign msb_sum   = (a_bit ^ a_inv) ^ (b_bit ^ b_inv) ^ carry_q;
  assign ovf_step  = carry_q ^ slice_cout;
  assign last_step = (idx_q == LAST_IDX);
  assign slt_set   = msb_sum_q ^ ovf_sub_q;

  always_comb begin
    res_next        = res_q;
    res_next[idx_q] = slice_res;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (abort)          state_d = S_IDLE;
        else if (last_step) state_d = (ctrl_q == OP_SLT) ? S_FIX : S_DONE;
      end
      S_FIX:   state_d = abort ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == S_RUN) || (state_q == S_FIX);
    done_o = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      ctrl_q    <= '0;
      idx_q     <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      msb_sum_q <= 1'b0;
      ovf_sub_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_q     <= src1_i;
            b_q     <= src2_i;
            ctrl_q  <= ctrl_i;
            idx_q   <= '0;
            res_q   <= '0;
            carry_q <= start_b_inv;
          end
        end
        S_RUN: begin
          if (!abort) begin
            res_q   <= res_next;
            carry_q <= slice_cout;
            idx_q   <= last_step ? '0 : idx_q + IW'(1);
            if (last_step) begin
              msb_sum_q <= msb_sum;
              ovf_sub_q <= ovf_step;
              if (ctrl_q != OP_SLT) begin
                result_q <= op_valid ? res_next : '0;
                zero_q   <= op_valid ? (res_next == '0) : 1'b1;
                cout_q   <= is_arith & slice_cout;
                ovf_q    <= is_addsub & ovf_step;
              end
            end
          end
        end
        S_FIX: begin
          if (!abort) begin
            result_q <= {{(WIDTH-1){1'b0}}, slt_set};
            zero_q   <= ~slt_set;
            cout_q   <= carry_q;
            ovf_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_serial_ctrl
// Brief    : Directed self-checking bench for alu_serial_ctrl (WIDTH = 32).
// Revision : 1.0
// ============================================================================

module tb_alu_serial_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  ctrl_i = 4'b0000;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, zero_o, cout_o, overflow_o;
  logic [31:0] result_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  alu_serial_ctrl #(.WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .ctrl_i     (ctrl_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
`ifdef ALU_SERIAL_ABORT_EN
    .abort_i    (abort_i),
`endif
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .cout_o     (cout_o),
    .overflow_o (overflow_o)
  );

  // Issues one op, returns edges from start to done (-1 if none), then
  // steps past the done cycle so the next start lands in IDLE.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; src1_i = ~a; src2_i = ~b; ctrl_i = ~c;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk_i); #1;
      if (done_o) begin lat = n; break; end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    if ({busy_o, done_o, zero_o, cout_o, overflow_o} !== 5'b0 || result_o !== 32'h0) begin
      $display("FAIL reset: busy=%b done=%b res=%h z=%b c=%b v=%b, required all 0",
               busy_o, done_o, result_o, zero_o, cout_o, overflow_o);
      fails++;
    end
    tests++;
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    if (lat !== 32) begin $display("FAIL add_latency: got %0d required 32", lat); fails++; end
    tests++;
    if (result_o !== 32'h8000_0000 || overflow_o !== 1'b1 || cout_o !== 1'b0 || zero_o !== 1'b0) begin
      $display("FAIL add_ovf: res=%h v=%b c=%b z=%b, required 80000000 v=1 c=0 z=0",
               result_o, overflow_o, cout_o, zero_o);
      fails++;
    end
    tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL add_done_pulse: done=%b busy=%b one cycle after done, required 0 0", done_o, busy_o);
      fails++;
    end
    tests++;
  endtask

  task automatic test_sub();
    int lat;
    run_op(4'b0110, 32'd5, 32'd5, lat);
    if (result_o !== 32'h0 || zero_o !== 1'b1 || cout_o !== 1'b1 || overflow_o !== 1'b0 || lat !== 32) begin
      $display("FAIL sub_equal: res=%h z=%b c=%b v=%b lat=%0d, required 0 z=1 c=1 v=0 lat=32",
               result_o, zero_o, cout_o, overflow_o, lat);
      fails++;
    end
    tests++;
    run_op(4'b0110, 32'd0, 32'd1, lat);
    if (result_o !== 32'hFFFF_FFFF || cout_o !== 1'b0 || zero_o !== 1'b0 || overflow_o !== 1'b0) begin
      $display("FAIL sub_borrow: res=%h c=%b z=%b v=%b, required ffffffff c=0 z=0 v=0",
               result_o, cout_o, zero_o, overflow_o);
      fails++;
    end
    tests++;
  endtask

  task automatic test_slt();
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic [31:0] r_v [3];
    int lat;
    a_v[0] = 32'hFFFF_FFFD; b_v[0] = 32'h0000_0002; r_v[0] = 32'd1;
    a_v[1] = 32'h8000_0000; b_v[1] = 32'h0000_0001; r_v[1] = 32'd1;
    a_v[2] = 32'h7FFF_FFFF; b_v[2] = 32'hFFFF_FFFF; r_v[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      run_op(4'b0111, a_v[i], b_v[i], lat);
      if (result_o !== r_v[i] || lat !== 33 || overflow_o !== 1'b0 || zero_o !== (r_v[i] == 0)) begin
        $display("FAIL slt_%0d: res=%h lat=%0d v=%b z=%b, required %h lat=33 v=0 z=%b",
                 i, result_o, lat, overflow_o, zero_o, r_v[i], (r_v[i] == 0));
        fails++;
      end
      tests++;
    end
  endtask

  task automatic test_logic();
    logic [3:0]  c_v [3];
    logic [31:0] r_v [3];
    int lat;
    c_v[0] = 4'b1100; r_v[0] = 32'hF000_0000;
    c_v[1] = 4'b0000; r_v[1] = 32'h0000_0000;
    c_v[2] = 4'b0001; r_v[2] = 32'h0FFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      run_op(c_v[i], 32'h0F0F_0000, 32'h00F0_FFFF, lat);
      if (result_o !== r_v[i] || cout_o !== 1'b0 || overflow_o !== 1'b0 ||
          zero_o !== (r_v[i] == 0) || lat !== 32) begin
        $display("FAIL logic_op%b: res=%h c=%b v=%b z=%b lat=%0d, required %h c=0 v=0 z=%b lat=32",
                 c_v[i], result_o, cout_o, overflow_o, zero_o, lat, r_v[i], (r_v[i] == 0));
        fails++;
      end
      tests++;
    end
  endtask

  task automatic test_unsupported();
    int lat;
    run_op(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    if (result_o !== 32'h0 || zero_o !== 1'b1 || cout_o !== 1'b0 || overflow_o !== 1'b0 || lat !== 32) begin
      $display("FAIL unsupported: res=%h z=%b c=%b v=%b lat=%0d, required 0 z=1 c=0 v=0 lat=32",
               result_o, zero_o, cout_o, overflow_o, lat);
      fails++;
    end
    tests++;
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    if (result_o !== 32'h0 || cout_o !== 1'b1 || zero_o !== 1'b1 || overflow_o !== 1'b0) begin
      $display("FAIL b2b_first: res=%h c=%b z=%b v=%b, required 0 c=1 z=1 v=0",
               result_o, cout_o, zero_o, overflow_o);
      fails++;
    end
    tests++;
    run_op(4'b0010, 32'h1234_0000, 32'h0000_5678, lat);
    if (result_o !== 32'h1234_5678 || lat !== 32 || cout_o !== 1'b0) begin
      $display("FAIL b2b_second: res=%h lat=%0d c=%b, required 12345678 lat=32 c=0", result_o, lat, cout_o);
      fails++;
    end
    tests++;
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int first = -1;
    logic busy5 = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'd1; src2_i = 32'd2;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5 || n == 31) begin
        start_i = 1'b1; ctrl_i = 4'b0000; src1_i = 32'hFFFF_FFFF; src2_i = 32'hFFFF_FFFF;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk_i); #1;
      if (n == 5) busy5 = busy_o;
      if (done_o) begin
        dones++;
        if (first < 0) first = n;
      end
    end
    start_i = 1'b0;
    if (dones !== 1 || first !== 32 || result_o !== 32'd3 || busy5 !== 1'b1) begin
      $display("FAIL start_ignored: dones=%0d first=%0d res=%h busy@5=%b, required 1 32 00000003 1",
               dones, first, result_o, busy5);
      fails++;
    end
    tests++;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int lat;
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'hFFFF_0000; src2_i = 32'h0000_FFFF;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk_i); #1;
      if (done_o) dones++;
    end
    #1 rst_n = 1'b0;
    #1;
    if ({busy_o, done_o, zero_o, cout_o, overflow_o} !== 5'b0 || result_o !== 32'h0) begin
      $display("FAIL reset_mid: busy=%b done=%b res=%h z=%b c=%b v=%b, required all 0",
               busy_o, done_o, result_o, zero_o, cout_o, overflow_o);
      fails++;
    end
    tests++;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o) dones++;
    end
    if (dones !== 0) begin
      $display("FAIL reset_mid_no_done: done/busy seen %0d times, required 0", dones);
      fails++;
    end
    tests++;
    run_op(4'b0010, 32'd2, 32'd3, lat);
    if (result_o !== 32'd5 || lat !== 32) begin
      $display("FAIL reset_mid_recover: res=%h lat=%0d, required 00000005 lat=32", result_o, lat);
      fails++;
    end
    tests++;
  endtask

`ifdef ALU_SERIAL_ABORT_EN
  task automatic test_abort();
    int dones = 0;
    int lat;
    logic busy_after;
    logic [31:0] prev;
    prev = result_o;
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'd100; src2_i = 32'd200;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      @(posedge clk_i); #1;
      if (done_o) dones++;
    end
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    busy_after = busy_o;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk_i); #1;
      if (done_o) dones++;
    end
    if (busy_after !== 1'b0 || dones !== 0 || result_o !== prev) begin
      $display("FAIL abort: busy=%b dones=%0d res=%h, required 0 0 %h", busy_after, dones, result_o, prev);
      fails++;
    end
    tests++;
    run_op(4'b0010, 32'd7, 32'd8, lat);
    if (result_o !== 32'd15 || lat !== 32) begin
      $display("FAIL abort_recover: res=%h lat=%0d, required 0000000f lat=32", result_o, lat);
      fails++;
    end
    tests++;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_unsupported();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
`ifdef ALU_SERIAL_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial ALU sequencer: computes one WIDTH-bit ALU operation by driving a single 1-bit ALU slice (alu_top) once per clock, LSB first.
- Holds the ripple carry in a flop between bits and shifts result bits into a register.
- Post-processes SLT, then reports the result and flags with a start/done handshake.
- Area-minimal ALU for the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; valid range 2 to 64.

Ports:
- clk_i  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  request pulse; sampled only in IDLE
- ctrl_i  input  4  op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- src1_i  input  WIDTH  operand A; latched at start
- src2_i  input  WIDTH  operand B; latched at start
- busy_o  output  1  high while in RUN or FIX
- done_o  output  1  one-cycle pulse; result and flags valid from this cycle
- result_o  output  WIDTH  registered result; held until the next done
- zero_o  output  1  result_o == 0; registered with done
- cout_o  output  1  MSB carry-out for ADD/SUB/SLT, 0 otherwise
- overflow_o  output  1  signed overflow for ADD/SUB, 0 otherwise

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - busy_o, done_o, result_o, zero_o, cout_o, overflow_o all 0.
  - Operand, result, carry and index registers all 0.
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE: start_i high at a rising edge latches src1_i, src2_i and ctrl_i, clears idx and the result shift register, loads carry = b_invert, then goes to RUN.
  - RUN: each edge feeds bit idx of A and B plus the carry flop to the slice. The slice result is shifted into bit idx, the carry flop takes the slice cout, and idx increments.
  - On the edge that processes idx == WIDTH-1, go to FIX if op is SLT, else DONE.
  - FIX (SLT only): set = msb_sum XOR overflow_sub; result[0] = set; all other bits 0. Then go to DONE.
  - DONE: done_o = 1 for exactly one cycle; result_o and flags updated on entry. Next state is IDLE.
- Slice control decode:
  - AND: a_inv=0, b_inv=0, op=00
  - OR: 0, 0, 01
  - ADD: 0, 0, 10
  - SUB: 0, 1, 10
  - SLT: 0, 1, 11, less=0
  - NOR: 1, 1, 00
- msb_sum = a^b^cin computed by the controller at the MSB step, because the slice outputs `less` for op 11.
- overflow = cin_msb XOR cout_msb, captured at the MSB step.
- Latency, counted from the start edge: done_o is high in the cycle following edge WIDTH (32 cycles at default), and following edge WIDTH+1 for SLT.
- Back-to-back: the earliest next start is the cycle after done_o.
- Unsupported ctrl_i codes: run the full WIDTH cycles and complete with result 0, zero_o=1, cout_o=0, overflow_o=0.
- start_i while busy or in DONE: ignored, no queuing. Operand inputs are don't-care after the start edge.
- Reset mid-operation: immediate abort to reset values; no done_o is generated.

Optional Feature:
- Macro: ALU_SERIAL_ABORT_EN.
- Defined: adds input abort_i (1 bit). abort_i high at an edge in RUN or FIX returns the FSM to IDLE next cycle. done_o is not pulsed and result_o and flags keep their previous values; abort_i has no effect in IDLE or DONE.
- Undefined: port absent; every accepted operation runs to completion.

Test Plan:
- ADD, A=0x7FFFFFFF, B=0x00000001 -> done_o exactly 32 cycles after start; result_o=0x80000000, overflow_o=1, cout_o=0, zero_o=0.
- SUB, A=5, B=5 -> result_o=0, zero_o=1, cout_o=1, overflow_o=0. Then SUB A=0, B=1 -> result_o=0xFFFFFFFF, cout_o=0.
- SLT cases, each with done_o at 33 cycles:
  - A=0xFFFFFFFD (-3), B=2 -> result_o=1.
  - A=0x80000000, B=1 (overflow case) -> result_o=1.
  - A=0x7FFFFFFF, B=0xFFFFFFFF -> result_o=0.
- NOR A=0x0F0F0000, B=0x00F0FFFF -> 0xF0000000; AND/OR on the same operands -> 0x00000000 and 0x0FFFFFFF; cout_o=0.
- start_i re-asserted on cycles 5 and 31 of an ADD -> ignored; single done_o. Separately, rst_n low at cycle 10 -> all outputs 0 immediately, no done_o, and a new op started after reset completes correctly.
- With ALU_SERIAL_ABORT_EN: abort_i at cycle 12 of an ADD -> busy_o low next cycle, no done_o, result_o unchanged; the following op completes normally.
